// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO; 8 data bits, LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
   parameter int BAUD_DIV   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       TxD
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count, w_count_nxt;
   logic          r_full, r_empty, r_ovf;
   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_baud, w_baud_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          r_txd, w_txd_nxt;
   logic          w_push, w_pop, w_baud_done;
`ifdef UART_TX_PARITY_EN
   logic          r_par, w_par_nxt;
`endif

   // A write while full is dropped even if the FSM pops in the same cycle.
   assign w_push      = we & ~r_full;
   assign w_baud_done = (r_baud == '0);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         IDLE: w_pop = ~r_empty;
         START:
            if (w_baud_done) begin
               w_state_nxt = DATA;
               w_baud_nxt  = BAUD_LAST;
               w_bit_nxt   = 3'd0;
            end else
               w_baud_nxt = r_baud - 1'b1;
         DATA:
            if (w_baud_done) begin
               w_baud_nxt = BAUD_LAST;
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end else
               w_baud_nxt = r_baud - 1'b1;
`ifdef UART_TX_PARITY_EN
         PARITY:
            if (w_baud_done) begin
               w_state_nxt = STOP;
               w_baud_nxt  = BAUD_LAST;
            end else
               w_baud_nxt = r_baud - 1'b1;
`endif
         STOP:
            if (w_baud_done) begin
               w_pop       = ~r_empty;
               w_state_nxt = IDLE;
               w_baud_nxt  = '0;
            end else
               w_baud_nxt = r_baud - 1'b1;
         default: w_state_nxt = IDLE;
      endcase

      // Popping a byte always starts a new frame, from IDLE or straight out of STOP.
      if (w_pop) begin
         w_state_nxt = START;
         w_baud_nxt  = BAUD_LAST;
         w_shift_nxt = r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
         w_par_nxt   = ^r_mem[r_rptr];
`endif
      end

      case (w_state_nxt)
         START:   w_txd_nxt = 1'b0;
         DATA:    w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_txd_nxt = w_par_nxt;
`endif
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_txd   <= 1'b1;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_txd   <= w_txd_nxt;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_FULL);
         if (we && r_full)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wptr] <= din;
      r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
   end

   assign full  = r_full;
   assign empty = r_empty;
   assign busy  = (r_state != IDLE);
   assign ovf   = r_ovf;
   assign TxD   = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (BAUD_DIV=4 main instance, BAUD_DIV=2 second instance).
module tb_uart_tx_fifo;

   localparam int BAUD = 4;

   logic       clk = 1'b0;
   logic       reset, we, ovf_clr;
   logic [7:0] din;
   logic       full, empty, busy, ovf, TxD;
   logic       we2, ovf_clr2;
   logic [7:0] din2;
   logic       full2, empty2, busy2, ovf2, TxD2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .we(we), .din(din), .full(full), .empty(empty),
      .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr), .TxD(TxD)
   );

   uart_tx_fifo #(.BAUD_DIV(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .reset(reset), .we(we2), .din(din2), .full(full2), .empty(empty2),
      .busy(busy2), .ovf(ovf2), .ovf_clr(ovf_clr2), .TxD(TxD2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walks one frame cycle by cycle; nstart/nbit0 allow joining a frame already in progress.
   task automatic frame(input logic [7:0] b, input int nstart, input int nbit0);
      for (int i = 0; i < nstart; i++) begin
         step();
         we = 1'b0;
         chk("start_bit", TxD, 0);
         chk("busy_in_frame", busy, 1);
      end
      for (int k = 0; k < 8; k++) begin
         int n;
         n = (k == 0) ? nbit0 : BAUD;
         for (int j = 0; j < n; j++) begin
            step();
            chk("data_bit", TxD, b[k]);
         end
      end
`ifdef UART_TX_PARITY_EN
      for (int j = 0; j < BAUD; j++) begin
         step();
         chk("parity_bit", TxD, ^b);
      end
`endif
      for (int j = 0; j < BAUD; j++) begin
         step();
         chk("stop_bit", TxD, 1);
      end
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; din = 8'h00; ovf_clr = 1'b0;
      we2 = 1'b0; din2 = 8'h00; ovf_clr2 = 1'b0;
      repeat (3) step();
      chk("rst_txd", TxD, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      reset = 1'b0;
      repeat (2) step();
      chk("idle_txd", TxD, 1);

      // single byte 0x55
      we = 1'b1; din = 8'h55;
      step();
      we = 1'b0;
      chk("wr_edge_txd", TxD, 1);
      chk("wr_edge_busy", busy, 0);
      chk("wr_edge_empty", empty, 0);
      frame(8'h55, BAUD, BAUD);
      step();
      chk("single_busy_fall", busy, 0);
      chk("single_txd_idle", TxD, 1);
      chk("single_empty", empty, 1);

      // back-to-back 0xA5, 0x3C
      we = 1'b1; din = 8'hA5;
      step();
      din = 8'h3C;
      frame(8'hA5, BAUD, BAUD);
      chk("b2b_queued", empty, 0);
      frame(8'h3C, BAUD, BAUD);
      chk("b2b_empty", empty, 1);
      step();
      chk("b2b_busy_fall", busy, 0);

      // overflow: 0x01..0x06, then 0x07 with ovf_clr on the same edge
      for (int i = 0; i < 7; i++) begin
         we = 1'b1; din = 8'(i + 1); ovf_clr = (i == 6);
         step();
         if (i >= 1 && i <= 4) chk("ovf_start_bit", TxD, 0);
         if (i == 4) begin
            chk("ovf_full", full, 1);
            chk("ovf_not_yet", ovf, 0);
         end
         if (i == 5) chk("ovf_set", ovf, 1);
         if (i == 6) chk("ovf_set_wins", ovf, 1);
      end
      we = 1'b0; ovf_clr = 1'b0;
      frame(8'h01, 0, BAUD - 2);
      frame(8'h02, BAUD, BAUD);
      frame(8'h03, BAUD, BAUD);
      frame(8'h04, BAUD, BAUD);
      frame(8'h05, BAUD, BAUD);
      step();
      chk("ovf_drained_busy", busy, 0);
      chk("ovf_drained_empty", empty, 1);
      chk("ovf_sticky", ovf, 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 0);

      // parity-relevant bytes (parity bit only present when compiled in)
      we = 1'b1; din = 8'h07;
      step();
      we = 1'b0;
      frame(8'h07, BAUD, BAUD);
      step();
      chk("p07_busy_fall", busy, 0);
      we = 1'b1; din = 8'h03;
      step();
      we = 1'b0;
      frame(8'h03, BAUD, BAUD);
      step();
      chk("p03_busy_fall", busy, 0);

      // reset mid-frame during bit 3 of 0xFF with two bytes queued
      we = 1'b1; din = 8'hFF;
      step();
      din = 8'h11;
      step();
      din = 8'h22;
      step();
      we = 1'b0;
      chk("rmf_queued", empty, 0);
      repeat (15) step();
      chk("rmf_bit3", TxD, 1);
      chk("rmf_busy_before", busy, 1);
      reset = 1'b1; we = 1'b1; din = 8'h33;
      step();
      reset = 1'b0; we = 1'b0;
      chk("rmf_txd", TxD, 1);
      chk("rmf_empty", empty, 1);
      chk("rmf_busy", busy, 0);
      chk("rmf_full", full, 0);
      for (int i = 0; i < 3 * 10 * BAUD; i++) begin
         step();
         chk("rmf_quiet_txd", TxD, 1);
      end
      chk("rmf_quiet_busy", busy, 0);

      // BAUD_DIV=2 instance sending 0x80
      we2 = 1'b1; din2 = 8'h80;
      step();
      we2 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk("div2_txd", TxD2, (c >= 17) ? 1 : 0);
      end
`ifdef UART_TX_PARITY_EN
      repeat (2) step();
`endif
      step();
      chk("div2_busy_fall", busy2, 0);
      chk("div2_empty", empty2, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the transmit FIFO (power of two, 2..16).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  write strobe; one byte offered per cycle while high.
REQ-006 din  input  8  byte to transmit, sampled when we=1.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 empty  output  1  FIFO holds zero bytes.
REQ-009 busy  output  1  high while a frame is on the line (any state except IDLE).
REQ-010 ovf  output  1  sticky overflow flag.
REQ-011 ovf_clr  input  1  clears ovf.
REQ-012 TxD  output  1  serial line; idle level 1.

Function
REQ-013 The FIFO shall accept din at the edge where we=1 and full=0.
REQ-014 A write with full=1 shall be dropped and shall set ovf at the same edge, even if a pop occurs in that cycle.
REQ-015 full and empty shall be registered, reflecting occupancy after each edge; occupancy shall wrap pointers modulo FIFO_DEPTH without loss.
REQ-016 The transmitter FSM shall have the states IDLE, START, DATA, PARITY, and STOP.
REQ-017 IDLE -> START shall occur at the first edge where empty=0, popping the head byte into a shift register at that edge.
REQ-018 A write at edge N into an empty FIFO while IDLE shall cause TxD=0 (start bit) from edge N+1.
REQ-019 Each bit shall last exactly BAUD_DIV cycles, timed by a down-counter reloaded on every state or bit change.
REQ-020 START shall drive 0, then go to DATA.
REQ-021 DATA shall send 8 bits LSB first, with a 3-bit index from 0 to 7.
REQ-022 After bit 7, DATA shall go to PARITY if compiled in (REQ-031), else to STOP.
REQ-023 STOP shall drive 1 for BAUD_DIV cycles.
REQ-024 At the end of STOP, with the FIFO non-empty, the FSM shall pop the next byte and enter START at that edge, leaving no idle gap.
REQ-025 At the end of STOP, with the FIFO empty, the FSM shall enter IDLE.
REQ-026 The frame length shall be 10*BAUD_DIV cycles, or 11*BAUD_DIV cycles with parity.
REQ-027 TxD shall be driven from a flop and shall have no combinational path from we or din.
REQ-028 When ovf_clr and an overflowing write coincide, the set shall win.

Reset
REQ-029 While reset=1 at an edge, the block shall set state=IDLE, TxD=1, pointers=0, empty=1, full=0, busy=0, ovf=0, and baud counter=0.
REQ-030 A reset mid-frame shall abort the frame at that edge (TxD=1 next cycle), discard queued bytes, and ignore we in the same cycle.

Configuration
REQ-031 With UART_TX_PARITY_EN defined, a PARITY state shall follow DATA and send an even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles.
REQ-032 Without UART_TX_PARITY_EN, the PARITY state and its logic shall be absent, and DATA shall go directly to STOP.

Verification (BAUD_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-033 Single byte: reset, then write 0x55 at edge N -> TxD=0 during cycles N+1..N+4; bits 1,0,1,0,1,0,1,0 at 4 cycles each; stop=1 during cycles N+37..N+40; busy falls at N+41.
REQ-034 Back-to-back: write 0xA5 and 0x3C on consecutive edges -> two frames with the second start bit immediately after the first stop bit; empty=1 after the second pop.
REQ-035 Overflow: hold we for 6 cycles with bytes 0x01..0x06 while the line is idle at start -> first pop frees one slot, 0x01..0x05 are transmitted, 0x06 is dropped, and ovf=1; pulse ovf_clr -> ovf=0.
REQ-036 Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued -> TxD=1, empty=1, and busy=0 on the next cycle; no further frames.
REQ-037 Parity build: send 0x07 with UART_TX_PARITY_EN -> parity bit=1 and frame is 44 cycles; send 0x03 -> parity bit=0.
REQ-038 Divider edge: BAUD_DIV=2, send 0x80 -> every bit lasts exactly 2 cycles and the MSB=1 appears in cycles 17..18 after the start edge.
